// File: rtl/operand_fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Shadows the destination registers in EX and MEM, registers the EX operand
// mux selects one cycle ahead, and stalls ID for one cycle on a load-use pair.
module operand_fwd_ctrl (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    output logic [1:0]  sel_a,
    output logic [1:0]  sel_b,
    output logic        stall,
    output logic        ex_valid,
    output logic [15:0] stall_count
);

    typedef enum logic {RUN, STALL} ctrlState_t;

    ctrlState_t  state;
    ctrlState_t  stateNext;

    // EX shadow slot
    logic        exValid;
    logic [4:0]  exRd;
    logic        exRegWrite;
    logic        exMemRead;

    // MEM shadow slot
    logic        memValid;
    logic [4:0]  memRd;
    logic        memRegWrite;

    logic        matchExRs;
    logic        matchExRt;
    logic        matchMemRs;
    logic        matchMemRt;
    logic        hazard;
    logic        issue;
    logic [15:0] stallCnt;

    // Newest producer wins; anything older than MEM is covered by write-through.
    function automatic logic [1:0] fwdSelect(input logic exMatch, input logic memMatch);
        if (exMatch)
            return 2'd1;
        else if (memMatch)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [15:0] satInc(input logic [15:0] value);
        if (value == 16'hFFFF)
            return value;
        else
            return value + 16'd1;
    endfunction

    // Producer/source match terms; register 0 never forwards.
    always_comb begin
        matchExRs  = exValid  & exRegWrite  & (exRd  == id_rs) & (id_rs != 5'd0) & id_uses_rs;
        matchExRt  = exValid  & exRegWrite  & (exRd  == id_rt) & (id_rt != 5'd0) & id_uses_rt;
        matchMemRs = memValid & memRegWrite & (memRd == id_rs) & (id_rs != 5'd0) & id_uses_rs;
        matchMemRt = memValid & memRegWrite & (memRd == id_rt) & (id_rt != 5'd0) & id_uses_rt;
        hazard     = id_valid & ~flush & exValid & exMemRead & (matchExRs | matchExRt);
    end

    // Stall FSM: one stall cycle per load-use pair; flush suppresses the hazard.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        case (state)
            RUN: begin
                stall = hazard;
                if (hazard)
                    stateNext = STALL;
            end
            STALL: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign issue       = id_valid & ~stall & ~flush;
    assign ex_valid    = exValid;
    assign stall_count = stallCnt;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state <= RUN;
        else
            state <= stateNext;
    end

    // Advance the shadow slots; a non-issuing cycle inserts a bubble into EX.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            exValid     <= 1'b0;
            exRd        <= 5'd0;
            exRegWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            memValid    <= 1'b0;
            memRd       <= 5'd0;
            memRegWrite <= 1'b0;
        end else begin
            memValid    <= exValid;
            memRd       <= exRd;
            memRegWrite <= exRegWrite;
            if (issue) begin
                exValid    <= 1'b1;
                exRd       <= id_rd;
                exRegWrite <= id_regwrite;
                exMemRead  <= id_memread;
            end else begin
                exValid    <= 1'b0;
                exRd       <= 5'd0;
                exRegWrite <= 1'b0;
                exMemRead  <= 1'b0;
            end
        end
    end

    // Register the operand selects so they line up with the EX cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_a <= 2'd0;
            sel_b <= 2'd0;
        end else if (issue) begin
            sel_a <= fwdSelect(matchExRs, matchMemRs);
            sel_b <= fwdSelect(matchExRt, matchMemRt);
        end else begin
            sel_a <= 2'd0;
            sel_b <= 2'd0;
        end
    end

    // Saturating count of stall cycles for performance reporting.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            stallCnt <= 16'd0;
        else if (stall)
            stallCnt <= satInc(stallCnt);
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Directed bench for operand_fwd_ctrl: forwarding selects, load-use stall,
// zero register, flush, asynchronous reset and counter saturation.
module tb_operand_fwd_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        flush;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic        stall;
    logic        ex_valid;
    logic [15:0] stall_count;

    int vecCount = 0;
    int missCount = 0;

    operand_fwd_ctrl dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .stall_count (stall_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_uses_rs  = urs;
        id_rt       = rt;
        id_uses_rt  = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        #1;
    endtask

    task automatic idle2();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    // One LW rd=5 followed by a dependent ADD rt=5 through to ADD's EX cycle.
    task automatic loadUsePair();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check("reset_sel_a", sel_a, 2'd0);
        check("reset_sel_b", sel_b, 2'd0);
        check("reset_stall", stall, 1'b0);
        check("reset_ex_valid", ex_valid, 1'b0);
        check("reset_count", stall_count, 16'd0);
        Reset_n = 1'b1;
        tick();

        // EX-to-EX: ADD rd=8, SUB rs=8 rt=9
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        check("add_ex_valid", ex_valid, 1'b1);
        drive(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        check("exex_no_stall", stall, 1'b0);
        tick();
        check("exex_sel_a", sel_a, 2'd1);
        check("exex_sel_b", sel_b, 2'd0);
        idle2();

        // Two producers of r8: newest (EX) wins
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        check("prio_sel_a", sel_a, 2'd1);
        idle2();

        // Middle instruction writes r10: r8 comes from MEM
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        check("mem_sel_a", sel_a, 2'd2);
        check("mem_sel_b", sel_b, 2'd0);

        // Asynchronous reset mid-run clears the nonzero select
        #2;
        Reset_n = 1'b0;
        #1;
        check("midrun_rst_sel_a", sel_a, 2'd0);
        check("midrun_rst_ex_valid", ex_valid, 1'b0);
        Reset_n = 1'b1;
        idle2();

        // Load-use: LW rd=5, ADD rt=5
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        check("lu_stall", stall, 1'b1);
        tick();
        check("lu_stall_once", stall, 1'b0);
        check("lu_bubble", ex_valid, 1'b0);
        check("lu_count", stall_count, 16'd1);
        tick();
        check("lu_add_ex_valid", ex_valid, 1'b1);
        check("lu_sel_b", sel_b, 2'd2);
        check("lu_sel_a", sel_a, 2'd0);
        check("lu_count_hold", stall_count, 16'd1);
        idle2();

        // Zero register never forwards
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        check("zero_sel_a", sel_a, 2'd0);
        idle2();

        // Flush beats the load-use hazard
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        check("flush_no_stall", stall, 1'b0);
        tick();
        check("flush_bubble", ex_valid, 1'b0);
        check("flush_count", stall_count, 16'd1);
        check("flush_sel_b", sel_b, 2'd0);
        idle2();

        // Reset during the stall cycle drops all held state
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        check("rst2_stall", stall, 1'b1);
        tick();
        check("rst2_count_before", stall_count, 16'd2);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst2_count", stall_count, 16'd0);
        check("rst2_stall_low", stall, 1'b0);
        check("rst2_ex_valid", ex_valid, 1'b0);
        Reset_n = 1'b1;
        #1;
        check("rst2_no_stall_after", stall, 1'b0);
        tick();
        check("rst2_issue_ex_valid", ex_valid, 1'b1);
        check("rst2_issue_sel_b", sel_b, 2'd0);
        idle2();

        // Saturation: preload near the top, then add load-use pairs
        force dut.stallCnt = 16'hFFFE;
        #1;
        release dut.stallCnt;
        #1;
        loadUsePair();
        check("sat_reach_max", stall_count, 16'hFFFF);
        idle2();
        loadUsePair();
        check("sat_hold_max", stall_count, 16'hFFFF);
        idle2();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/operand_fwd_ctrl.md
# operand_fwd_ctrl

Operand-forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination registers in flight in its own EX and MEM shadow slots. Each cycle it produces the registered select codes for the two EX-stage 32-bit 3-input operand muxes (register file / EX-MEM result / MEM-WB result). It also stalls ID for one cycle on a load-use hazard. It sits between decode and the EX-stage operand muxes and keeps a saturating stall counter for performance reporting.

## Interface
- No parameters; the register index is fixed at 5 bits and the counter at 16 bits.
- Clk  input  1  pipeline clock; all state updates on the rising edge
- Reset_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs, id_rt  input  5  source register indices of the ID instruction
- id_uses_rs, id_uses_rt  input  1  the ID instruction reads rs / rt
- id_rd  input  5  destination register of the ID instruction
- id_regwrite  input  1  the ID instruction writes id_rd
- id_memread  input  1  the ID instruction is a load
- flush  input  1  kill the ID instruction this cycle (branch/jump redirect)
- sel_a, sel_b  output  2  EX operand mux selects: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result; 3 is never driven
- stall  output  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  output  1  the EX slot holds an issued instruction
- stall_count  output  16  number of stall cycles, saturating

## Operation
- **Shadow slots:**
  - ex_slot = {valid, rd, regwrite, memread}; mem_slot = {valid, rd, regwrite}.
  - Every edge: mem_slot <= ex_slot. ex_slot <= ID fields if issue, else a bubble (all fields zero).
  - issue = id_valid & ~stall & ~flush.
- **Match rule:** producer slot X matches source s when X.valid & X.regwrite & X.rd == s & s != 0 & the use flag for s is set.
- **Select computation (on issue, per source):**
  - ex_slot match -> 1.
  - Else mem_slot match -> 2.
  - Else -> 0.
  - The newest producer wins when both slots match.
  - The value is registered into sel_a/sel_b, so it is valid in the cycle the instruction is in EX.
  - On a bubble, sel_a/sel_b <= 0.
- **Load-use hazard:** hazard = id_valid & ~flush & ex_slot.valid & ex_slot.memread & ex_slot match on rs or rt.
- **FSM states:**
  - RUN: stall = hazard. If hazard, go to STALL and insert a bubble into ex_slot.
  - STALL: stall = 0 and return to RUN. ex_slot is a bubble, so the hazard cannot recur. The held instruction then issues and sees the load in mem_slot, giving select 2.
- **Other rules:**
  - flush has priority over hazard: stall = 0, no count, and a bubble is inserted.
  - A producer that has passed MEM is covered by register-file write-through, so the select is 0.
  - stall_count increments on each cycle with stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, Reset_n = 0) sets:
  - slots invalid, FSM = RUN, sel_a = sel_b = 0, ex_valid = 0, stall_count = 0.
  - stall reads 0 because the slots are invalid.
- Select latency: computed in cycle t when the instruction is in ID; visible on sel_a/sel_b in cycle t+1, its EX cycle.
- A load-use pair costs exactly one stall cycle. Back-to-back loads feeding each other stall once per pair.
- Reset asserted mid-stall drops the held state immediately. After release, the first issue sees empty slots.
- ex_valid mirrors ex_slot.valid.

## Test plan
- **Reset:** assert Reset_n = 0 mid-run -> sel_a = sel_b = 0, stall = 0, stall_count = 0, ex_valid = 0 asynchronously.
- **EX-to-EX forward:** issue ADD rd = 8, then the next cycle issue SUB rs = 8, rt = 9 -> sel_a = 1, sel_b = 0 during SUB's EX cycle, no stall.
- **Two-back forward with priority:**
  - ADD rd = 8, then OR rd = 8, then AND rs = 8 -> sel_a = 1 (newest producer).
  - Repeat with the middle instruction rd = 10 -> sel_a = 2.
- **Load-use:** LW rd = 5, then ADD rt = 5 -> stall = 1 for exactly one cycle, ex_valid = 0 for one cycle, ADD in EX with sel_b = 2, stall_count = 1.
- **Zero register and flush:**
  - Producer rd = 0 with consumer rs = 0 -> sel_a = 0.
  - LW rd = 5 followed by a dependent instruction with flush = 1 -> stall = 0, stall_count unchanged, bubble issued.
- **Saturation:** preload via 65 535 load-use pairs, then one more -> stall_count stays 16'hFFFF.
